// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM state encoding, frame defaults, CRC-32 byte step.
// Latency: n/a (package).
// Backpressure: n/a (package).
package eth_pkg;

    // Default minimum payload+pad length (64-byte frame minus 4-byte FCS).
    localparam int ETH_MIN_LEN = 60;

    // Default idle cycles enforced between frames.
    localparam int ETH_IFG = 12;

    // Reflected IEEE 802.3 polynomial and register seed.
    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    // Transmit framer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_FCS  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_t;

    // One byte of the LSB-first CRC-32 update; returns the new register value
    // without the final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc ^ {24'h0, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_fcs_if.sv
// Byte stream link: data/valid/last with ready handshake.
// Latency: n/a (wiring only).
// Backpressure: byte moves when valid && ready; producer holds data/last while stalled.
interface eth_tx_fcs_if;

    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    // Producer side drives the byte, consumer side drives ready.
    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/eth_crc32.sv
// Running Ethernet CRC-32 register, one byte per enabled cycle, no final inversion.
// Latency: crc reflects a byte the cycle after en; rst reseeds on the next edge.
// Backpressure: none; caller gates en.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic        rst,
    input  logic [7:0]  dat,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    // Reseed has priority over accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC32_INIT;
        end else if (en) begin
            r_crc <= crc32_byte(r_crc, dat);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/eth_tx_fcs.sv
// Ethernet TX framer: passes payload, zero-pads short frames, appends FCS, enforces IFG.
// Latency: 1 cycle from input accept to m.valid (single output register).
// Backpressure: input stalls whenever the output slot is full and m.ready is low, and
//   is closed during pad, FCS, inter-frame gap and the post-reset CRC seed cycle.
module eth_tx_fcs
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter bit PAD_EN  = 1'b1,
    parameter int IFG     = ETH_IFG
) (
    input  logic               clk,
    input  logic               rstn,
    eth_tx_fcs_if.slave        s,
    eth_tx_fcs_if.master       m,
    output logic               busy,
    output logic [15:0]        frames
);

    // Byte count threshold in counter width.
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    // The IDLE cycle in which the next first byte is accepted is itself a cycle with
    // m.valid low, so GAP only needs IFG-1 cycles to give IFG idle cycles on the line.
    localparam bit          GAP_SKIP  = (IFG <= 1);
    localparam logic [15:0] GAP_LAST  = (IFG >= 2) ? 16'(IFG - 2) : 16'd0;

    tx_state_t   r_state;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic        r_init_done;
    logic [15:0] r_cnt;
    logic [15:0] r_frames;
    logic [15:0] r_gap_cnt;
    logic [1:0]  r_fcs_idx;
    logic        r_fcs_done;

    logic        w_slot_free;
    logic        w_s_ready;
    logic        w_s_acc;
    logic        w_pad_load;
    logic        w_fcs_load;
    logic        w_fcs_last_load;
    logic        w_crc_en;
    logic        w_crc_rst;
    logic [7:0]  w_crc_dat;
    logic [7:0]  w_fcs_byte;
    logic [31:0] w_crc;
    logic [15:0] w_cnt_inc;
    logic        w_need_pad;

    // Output register can take a new byte when empty or being drained this cycle.
    assign w_slot_free     = !r_m_valid || m.ready;

    // Input is only open while collecting payload, and never before the CRC is seeded.
    assign w_s_ready       = r_init_done && w_slot_free &&
                             ((r_state == ST_IDLE) || (r_state == ST_DATA));
    assign w_s_acc         = w_s_ready && s.valid;

    assign w_pad_load      = (r_state == ST_PAD) && w_slot_free;
    assign w_fcs_load      = (r_state == ST_FCS) && !r_fcs_done && w_slot_free;
    assign w_fcs_last_load = w_fcs_load && (r_fcs_idx == 2'd3);

    // Every payload/pad byte enters the CRC in the cycle it enters the output register.
    assign w_crc_en        = w_s_acc || w_pad_load;
    assign w_crc_dat       = w_s_acc ? s.data : 8'h00;

    // Reseed once after reset release and as the final FCS byte leaves, so the next
    // frame starts from a clean register.
    assign w_crc_rst       = !r_init_done || w_fcs_last_load;

    // Saturating payload+pad count including the byte loading this cycle.
    assign w_cnt_inc       = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);
    assign w_need_pad      = PAD_EN && (w_cnt_inc < MIN_LEN_W);

    // The CRC register is frozen (en low) throughout FCS until the reseed that coincides
    // with byte 3, so it serves as the captured FCS value; byte 0 goes first.
    assign w_fcs_byte      = ~w_crc[{r_fcs_idx, 3'b000} +: 8];

    eth_crc32 u_crc (
        .clk (clk),
        .en  (w_crc_en),
        .rst (w_crc_rst),
        .dat (w_crc_dat),
        .crc (w_crc)
    );

    // Framer FSM together with the output register, byte counter and frame counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_m_data    <= 8'h00;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_init_done <= 1'b0;
            r_cnt       <= 16'd0;
            r_frames    <= 16'd0;
            r_gap_cnt   <= 16'd0;
            r_fcs_idx   <= 2'd0;
            r_fcs_done  <= 1'b0;
        end else begin
            r_init_done <= 1'b1;

            // Drain by default; a load below overrides in the same cycle.
            if (r_m_valid && m.ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_DATA: begin
                    if (w_s_acc) begin
                        r_m_data  <= s.data;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        r_cnt     <= w_cnt_inc;
                        if (s.last) begin
                            r_state <= w_need_pad ? ST_PAD : ST_FCS;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end

                ST_PAD: begin
                    if (w_pad_load) begin
                        r_m_data  <= 8'h00;
                        r_m_valid <= 1'b1;
                        r_m_last  <= 1'b0;
                        r_cnt     <= w_cnt_inc;
                        if (w_cnt_inc == MIN_LEN_W) begin
                            r_state <= ST_FCS;
                        end
                    end
                end

                ST_FCS: begin
                    if (w_fcs_load) begin
                        r_m_data  <= w_fcs_byte;
                        r_m_valid <= 1'b1;
                        r_m_last  <= (r_fcs_idx == 2'd3);
                        r_fcs_idx <= r_fcs_idx + 2'd1;
                        if (w_fcs_last_load) begin
                            r_fcs_done <= 1'b1;
                            r_frames   <= r_frames + 16'd1;
                        end
                    end else if (r_fcs_done && r_m_valid && m.ready) begin
                        // Final FCS byte consumed downstream.
                        r_fcs_done <= 1'b0;
                        r_gap_cnt  <= 16'd0;
                        if (GAP_SKIP) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.ready = w_s_ready;
    assign m.data  = r_m_data;
    assign m.valid = r_m_valid;
    assign m.last  = r_m_last;
    assign busy    = (r_state != ST_IDLE);
    assign frames  = r_frames;

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Directed bench for eth_tx_fcs: padding, FCS, IFG, backpressure, mid-frame reset.
// Latency: n/a (testbench).
// Backpressure: random m.ready on one frame, otherwise always ready.
module tb_eth_tx_fcs;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        busy, busy2;
    logic [15:0] frames, frames2;

    always #5 clk = ~clk;

    eth_tx_fcs_if s_if ();
    eth_tx_fcs_if m_if ();
    eth_tx_fcs_if s2_if ();
    eth_tx_fcs_if m2_if ();

    eth_tx_fcs #(.MIN_LEN(60), .PAD_EN(1'b1), .IFG(12)) u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .s      (s_if),
        .m      (m_if),
        .busy   (busy),
        .frames (frames)
    );

    eth_tx_fcs #(.MIN_LEN(60), .PAD_EN(1'b0), .IFG(12)) u_dut_np (
        .clk    (clk),
        .rstn   (rstn),
        .s      (s2_if),
        .m      (m2_if),
        .busy   (busy2),
        .frames (frames2)
    );

    // Independent CRC register used to compute the residue of each received frame.
    logic        chk_clk = 1'b0;
    logic        chk_en  = 1'b0;
    logic        chk_rst = 1'b0;
    logic [7:0]  chk_dat = 8'h00;
    logic [31:0] chk_crc;

    eth_crc32 u_chk (
        .clk (chk_clk),
        .en  (chk_en),
        .rst (chk_rst),
        .dat (chk_dat),
        .crc (chk_crc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Output capture.
    logic [7:0] mq0[$];
    logic       lq0[$];
    int         cq0[$];
    logic [7:0] mq1[$];
    logic       lq1[$];
    int         nlast0 = 0;
    int         nlast1 = 0;
    int         cyc = 0;
    int         stall_bad = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    logic       prev_last = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rstn && prev_stall &&
            (m_if.valid !== 1'b1 || m_if.data !== prev_dat || m_if.last !== prev_last))
            stall_bad++;
        prev_stall = m_if.valid && !m_if.ready;
        prev_dat   = m_if.data;
        prev_last  = m_if.last;
        if (m_if.valid && m_if.ready) begin
            mq0.push_back(m_if.data);
            lq0.push_back(m_if.last);
            cq0.push_back(cyc);
            if (m_if.last) nlast0++;
        end
        if (m2_if.valid && m2_if.ready) begin
            mq1.push_back(m2_if.data);
            lq1.push_back(m2_if.last);
            if (m2_if.last) nlast1++;
        end
    end

    // Downstream ready: always high, or coin-flip per cycle when bp_mode is set.
    int bp_mode = 0;
    initial begin
        m_if.ready  = 1'b1;
        m2_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = (bp_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] txq[$];   // payload to send / reference payload
    logic [7:0] fq[$];    // one captured output frame
    logic       flq[$];

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin
            s_if.valid = v; s_if.data = d; s_if.last = l;
        end else begin
            s2_if.valid = v; s2_if.data = d; s2_if.last = l;
        end
    endtask

    task automatic send(input int sel);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < txq.size() && t < 2000; i++) begin
            drive(sel, 1'b1, txq[i], (i == txq.size() - 1));
            @(negedge clk);
            while (!((sel == 0) ? s_if.ready : s2_if.ready) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
        check("send_accept", (t < 2000), 1);
    endtask

    task automatic wait_frames(input int sel, input int n);
        int t;
        t = 0;
        while (((sel == 0) ? nlast0 : nlast1) < n && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("frame_done", (t < 5000), 1);
    endtask

    task automatic clear_mon();
        mq0.delete(); lq0.delete(); cq0.delete(); mq1.delete(); lq1.delete();
        nlast0 = 0; nlast1 = 0;
    endtask

    // Copy one frame (up to and including its last byte) starting at index lo.
    task automatic grab(input int sel, input int lo);
        fq.delete();
        flq.delete();
        for (int i = lo; i < ((sel == 0) ? mq0.size() : mq1.size()); i++) begin
            fq.push_back((sel == 0) ? mq0[i] : mq1[i]);
            flq.push_back((sel == 0) ? lq0[i] : lq1[i]);
            if (flq[flq.size() - 1]) break;
        end
    endtask

    task automatic crc_feed(input logic r, input logic e, input logic [7:0] d);
        chk_rst = r; chk_en = e; chk_dat = d;
        #1 chk_clk = 1'b1;
        #1 chk_clk = 1'b0;
    endtask

    task automatic run_residue(output logic [31:0] r);
        crc_feed(1'b1, 1'b0, 8'h00);
        foreach (fq[i]) crc_feed(1'b0, 1'b1, fq[i]);
        chk_en  = 1'b0;
        chk_rst = 1'b0;
        r = chk_crc;
    endtask

    // Bit-serial reference CRC over the first n bytes of fq.
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fq[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    task automatic check_frame(input string tag, input int exp_len, input int pay_len);
        int          n, bad, lpos;
        logic [31:0] r, mc;
        n = fq.size();
        check({tag, "_len"}, n, exp_len);
        bad = 0;
        for (int i = 0; i < n - 4; i++) begin
            if (i < pay_len) begin
                if (i >= txq.size() || fq[i] !== txq[i]) bad++;
            end else if (fq[i] !== 8'h00) begin
                bad++;
            end
        end
        check({tag, "_payload_pad"}, bad, 0);
        if (n >= 4) begin
            mc = model_crc(n - 4);
            check({tag, "_fcs"}, {fq[n-1], fq[n-2], fq[n-3], fq[n-4]}, ~mc);
            lpos = flq[n-1] ? (n - 1) : -1;
            check({tag, "_last_pos"}, lpos, exp_len - 1);
        end
        run_residue(r);
        check({tag, "_residue"}, r, 32'hDEBB_20E3);
    endtask

    initial begin
        logic [31:0] r;
        int          t, gap;

        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_m_valid", m_if.valid, 0);
        check("rst_m_last",  m_if.last,  0);
        check("rst_m_data",  m_if.data,  8'h00);
        check("rst_s_ready", s_if.ready, 0);
        check("rst_busy",    busy,       0);
        check("rst_frames",  frames,     16'd0);

        // CRC seed cycle after release keeps the input closed for one cycle.
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("init_s_ready_low", s_if.ready, 0);
        @(negedge clk);
        check("init_s_ready_high", s_if.ready, 1);

        // Known answer for the CRC core: "123456789" -> 0xCBF43926.
        fq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_residue(r);
        check("crc_kat", ~r, 32'hCBF4_3926);

        // 100-byte incrementing payload: no pad, 104 bytes.
        clear_mon();
        txq.delete();
        for (int i = 0; i < 100; i++) txq.push_back(8'(i));
        send(0);
        check("inc100_busy", busy, 1);
        wait_frames(0, 1);
        grab(0, 0);
        check_frame("inc100", 104, 100);
        check("inc100_frames", frames, 16'd1);
        repeat (16) @(negedge clk);
        check("inc100_idle_busy", busy, 0);

        // Single 0xAA byte: padded to 60, 64 bytes total.
        clear_mon();
        txq = '{8'hAA};
        send(0);
        wait_frames(0, 1);
        grab(0, 0);
        check_frame("pad1", 64, 1);
        check("pad1_frames", frames, 16'd2);

        // Two back-to-back 60-byte payloads: 12 idle cycles between frames.
        clear_mon();
        txq.delete();
        for (int i = 0; i < 60; i++) txq.push_back(8'(8'hC3 - i));
        send(0);
        send(0);
        wait_frames(0, 2);
        grab(0, 0);
        check_frame("b2b_f1", 64, 60);
        grab(0, 64);
        check_frame("b2b_f2", 64, 60);
        gap = (cq0.size() >= 65) ? (cq0[64] - cq0[63] - 1) : -1;
        check("b2b_gap", gap, 12);
        check("b2b_frames", frames, 16'd4);

        // 70-byte payload under random backpressure.
        repeat (20) @(negedge clk);
        clear_mon();
        stall_bad = 0;
        bp_mode = 1;
        txq.delete();
        for (int i = 0; i < 70; i++) txq.push_back(8'(i) ^ 8'h5A);
        send(0);
        wait_frames(0, 1);
        bp_mode = 0;
        grab(0, 0);
        check_frame("bp70", 74, 70);
        check("bp70_stall_stable", stall_bad, 0);

        // Reset while FCS byte 2 sits in the output register.
        repeat (20) @(negedge clk);
        clear_mon();
        txq = '{8'hAA};
        send(0);
        t = 0;
        while (!(mq0.size() == 62 && m_if.valid) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("mrst_reached_fcs2", (t < 500), 1);
        rstn = 1'b0;
        #1;
        check("mrst_m_valid", m_if.valid, 0);
        check("mrst_m_last",  m_if.last,  0);
        check("mrst_frames",  frames,     16'd0);
        check("mrst_busy",    busy,       0);
        check("mrst_s_ready", s_if.ready, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        clear_mon();
        txq = '{8'hAA};
        send(0);
        wait_frames(0, 1);
        grab(0, 0);
        check_frame("mrst_pad1", 64, 1);
        check("mrst_frames_after", frames, 16'd1);

        // Padding disabled: 10-byte payload gives 14 bytes.
        clear_mon();
        txq.delete();
        for (int i = 0; i < 10; i++) txq.push_back(8'(8'h10 + i));
        send(1);
        wait_frames(1, 1);
        grab(1, 0);
        check_frame("nopad10", 14, 10);
        check("nopad10_frames", frames2, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_tx_fcs.md
ETH_TX_FCS -- requirements
Module: eth_tx_fcs

Interface
REQ-001 Parameters SHALL be:
  MIN_LEN, 60, minimum payload+pad byte count before FCS
  PAD_EN, 1, 1 = zero-pad short frames to MIN_LEN; 0 = no padding
  IFG, 12, idle cycles forced after each frame's last FCS byte (0 allowed)
REQ-002 Ports SHALL be:
  clk  in  1  sole clock; all state on rising edge
  rstn  in  1  asynchronous active-low reset
  s_data  in  8  payload byte
  s_valid  in  1  s_data valid
  s_last  in  1  final payload byte of frame
  s_ready  out  1  byte accepted when s_valid && s_ready
  m_data  out  8  frame byte (payload, pad, FCS)
  m_valid  out  1  m_data valid
  m_last  out  1  final FCS byte
  m_ready  in  1  byte consumed when m_valid && m_ready
  busy  out  1  state != IDLE
  frames  out  16  count of completed frames, wraps 0xFFFF->0

Function
REQ-003 States SHALL be IDLE, DATA, PAD, FCS, GAP.
REQ-004 Output SHALL be one register stage; a byte loads when the register is empty or m_ready is high ("slot free"); latency s-accept to m_valid = 1 cycle.
REQ-005 m_data/m_last SHALL hold stable while m_valid && !m_ready.
REQ-006 s_ready SHALL equal slot-free in IDLE and DATA, 0 in PAD, FCS, GAP and during CRC init.
REQ-007 IDLE->DATA on first accepted byte; DATA stays until byte with s_last accepted.
REQ-008 16-bit saturating byte counter SHALL count payload and pad bytes loaded; cleared on entry to IDLE.
REQ-009 On s_last accept: if PAD_EN and count (including that byte) < MIN_LEN -> PAD, else -> FCS.
REQ-010 PAD SHALL load 0x00 bytes per free slot until count == MIN_LEN, then -> FCS.
REQ-011 Each payload and pad byte SHALL be fed to eth_crc32 (en high, dat = byte) in the cycle it loads into the output register.
REQ-012 On FCS entry the crc value SHALL be captured; FCS byte k (k=0..3) = ~crc[8k+7:8k], emitted k=0 first, m_last high only with k=3.
REQ-013 eth_crc32 rst SHALL pulse for the cycle FCS byte 3 loads; frames increments in that cycle.
REQ-014 FCS -> GAP when byte 3 is accepted downstream; GAP holds m_valid low for IFG cycles then -> IDLE; IFG=0 goes directly to IDLE.
REQ-015 s_valid low mid-DATA SHALL insert no bytes (m_valid falls once register drains).

Reset
REQ-016 rstn low SHALL immediately force: state IDLE, m_valid 0, m_last 0, m_data 0x00, s_ready 0, busy 0, counter 0, frames 0; a partial frame is discarded.
REQ-017 After rstn release, eth_crc32 rst SHALL be asserted for one cycle (init flag) before s_ready may rise.

Structure
REQ-018 State enum and default MIN_LEN/IFG constants SHALL live in shared package eth_pkg.
REQ-019 Exactly one sub-module SHALL be instantiated: existing eth_crc32 (clk, en, rst, dat[7:0], crc[31:0]).

Verification
REQ-020 Bench SHALL check every output frame by feeding all bytes (incl. FCS) through a second eth_crc32: final value 0xDEBB20E3.
REQ-021 1-byte frame 0xAA, m_ready=1 -> 64 bytes: 0xAA, 59x 0x00, 4 FCS; m_last only on byte 64; residue passes.
REQ-022 100-byte incrementing frame -> 104 bytes, no pad, residue passes, frames=1.
REQ-023 Two back-to-back 64-byte frames, m_ready=1 -> exactly 12 cycles m_valid low between first m_last and next frame's first byte.
REQ-024 Random 50% m_ready backpressure on 70-byte frame -> byte sequence identical to no-backpressure run; m_data stable while stalled.
REQ-025 rstn pulsed during FCS byte 2 -> m_valid 0 same cycle, frames 0; following 1-byte frame yields correct 64-byte output and residue.
REQ-026 PAD_EN=0, 10-byte frame -> 14 bytes out, residue passes.
